// File: rtl/sram_test_pkg.sv
// Shared definitions for the SRAM pattern tester: FSM encoding and error counter width.
package sram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int ERR_W = 16;

endpackage

// File: rtl/sram_pattern_gen.sv
// Combinational test pattern: seed XOR address, address zero-extended or truncated to the word width.
module sram_pattern_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int AW = 5
) (
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [AW-1:0]         addr_i,
    output logic [DATA_WIDTH-1:0] pat_o
);

    logic [DATA_WIDTH-1:0] addr_ext;

    if (AW >= DATA_WIDTH) begin : g_trunc
        assign addr_ext = addr_i[DATA_WIDTH-1:0];
    end else begin : g_zext
        assign addr_ext = {{(DATA_WIDTH-AW){1'b0}}, addr_i};
    end

    assign pat_o = seed_i ^ addr_ext;

endmodule

// File: rtl/sram_pattern_tester.sv
// SRAM march-style tester: writes pat(a) to every word, reads everything back and counts mismatches.
module sram_pattern_tester
    import sram_test_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int AW = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  read_only,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic [ERR_W-1:0]      err_count,
    output logic [AW-1:0]         first_err_addr,
    output logic                  rd_enable_init,
    output logic                  wr_enable_init,
    output logic                  wclk_init,
    output logic                  rclk_init,
    output logic [AW-1:0]         raddr_init,
    output logic [AW-1:0]         waddr_init,
    output logic [DATA_WIDTH-1:0] mem_data_in_init,
    input  logic [DATA_WIDTH-1:0] mem_data_out_init
);

    localparam logic [AW-1:0] CNT_MAX = '1;
    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  vld_p0_q, vld_p0_d;
    logic [AW-1:0]         addr_p0_q, addr_p0_d;
    logic [ERR_W-1:0]      err_count_q, err_count_d;
    logic                  err_flag_q, err_flag_d;
    logic [AW-1:0]         first_err_q, first_err_d;
    logic [DATA_WIDTH-1:0] pat_wr, pat_chk;
    logic                  mismatch;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == {ERR_W{1'b1}}) ? v : v + ERR_W'(1);
    endfunction

    sram_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_pat_wr (
        .seed_i (seed_q),
        .addr_i (cnt_q),
        .pat_o  (pat_wr)
    );

    sram_pattern_gen #(.DATA_WIDTH(DATA_WIDTH), .AW(AW)) u_pat_chk (
        .seed_i (seed_q),
        .addr_i (addr_p0_q),
        .pat_o  (pat_chk)
    );

    // Compare stage: read data returns one cycle after the address, aligned with addr_p0_q
    assign mismatch = vld_p0_q && (mem_data_out_init != pat_chk);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_d      = seed_q;
        vld_p0_d    = 1'b0;
        addr_p0_d   = addr_p0_q;
        err_count_d = err_count_q;
        err_flag_d  = err_flag_q;
        first_err_d = first_err_q;

        if (mismatch) begin
            err_count_d = sat_inc(err_count_q);
            if (!err_flag_q) begin
                err_flag_d  = 1'b1;
                first_err_d = addr_p0_q;
            end
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    err_count_d = '0;
                    err_flag_d  = 1'b0;
                    seed_d      = seed;
                    cnt_d       = '0;
                    state_d     = read_only ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_MAX) state_d = ST_READ;
            end
            ST_READ: begin
                vld_p0_d  = 1'b1;
                addr_p0_d = cnt_q;
                cnt_d     = cnt_q + CNT_ONE;
                if (cnt_q == CNT_MAX) state_d = ST_CHECK;
            end
            ST_CHECK: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        // Abort drops the in-flight compare so the count freezes where it was
        if (abort) begin
            state_d     = ST_IDLE;
            vld_p0_d    = 1'b0;
            err_count_d = err_count_q;
            err_flag_d  = err_flag_q;
            first_err_d = first_err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            seed_q      <= '0;
            vld_p0_q    <= 1'b0;
            err_count_q <= '0;
            err_flag_q  <= 1'b0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_q      <= seed_d;
            vld_p0_q    <= vld_p0_d;
            err_count_q <= err_count_d;
            err_flag_q  <= err_flag_d;
            first_err_q <= first_err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_p0_q <= addr_p0_d;
    end

    // SRAM-side drive is decoded from state so reset forces the idle bus values immediately
    always_comb begin
        wr_enable_init   = (state_q == ST_WRITE);
        rd_enable_init   = (state_q == ST_READ);
        waddr_init       = wr_enable_init ? cnt_q  : '1;
        mem_data_in_init = wr_enable_init ? pat_wr : '0;
        raddr_init       = rd_enable_init ? cnt_q  : '0;
    end

    assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_CHECK);
    assign done           = (state_q == ST_DONE);
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign wclk_init      = clk;
    assign rclk_init      = clk;

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Directed bench for sram_pattern_tester with a synchronous-read SRAM model and fault injection.
module tb_sram_pattern_tester;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        read_only;
    logic        abort;
    logic [7:0]  seed;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [4:0]  first_err_addr;
    logic        rd_enable_init;
    logic        wr_enable_init;
    logic        wclk_init;
    logic        rclk_init;
    logic [4:0]  raddr_init;
    logic [4:0]  waddr_init;
    logic [7:0]  mem_data_in_init;
    logic [7:0]  mem_data_out_init;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mem [32];
    logic [7:0] rdata;
    logic [7:0] cur_seed = 8'h00;
    int         fmode = 0;
    logic [4:0] fault_addr = 5'd0;
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         wd_bad = 0;

    sram_pattern_tester dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .read_only         (read_only),
        .abort             (abort),
        .seed              (seed),
        .busy              (busy),
        .done              (done),
        .err_count         (err_count),
        .first_err_addr    (first_err_addr),
        .rd_enable_init    (rd_enable_init),
        .wr_enable_init    (wr_enable_init),
        .wclk_init         (wclk_init),
        .rclk_init         (rclk_init),
        .raddr_init        (raddr_init),
        .waddr_init        (waddr_init),
        .mem_data_in_init  (mem_data_in_init),
        .mem_data_out_init (mem_data_out_init)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fault(input logic [7:0] d, input logic [4:0] a);
        case (fmode)
            1:       return (a == fault_addr) ? (d ^ 8'h01) : d;
            2:       return 8'h00;
            3:       return (a < 5'd5) ? (d ^ 8'h01) : d;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (wr_enable_init) begin
            mem[waddr_init] <= mem_data_in_init;
            wr_cnt <= wr_cnt + 1;
            if (mem_data_in_init !== (cur_seed ^ {3'b000, waddr_init})) wd_bad <= wd_bad + 1;
        end
        if (rd_enable_init) begin
            rdata  <= fault(mem[raddr_init], raddr_init);
            rd_cnt <= rd_cnt + 1;
        end
    end

    assign mem_data_out_init = rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at a negedge; returns cycles from the start cycle until done is seen.
    task automatic run_test(input logic [7:0] sd, input logic ro, input int force_at, output int lat);
        cur_seed  = sd;
        seed      = sd;
        read_only = ro;
        start     = 1'b1;
        lat       = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) start = 1'b0;
            if (force_at > 0 && lat == force_at) force dut.err_count_q = 16'hFFFE;
            if (force_at > 0 && lat == force_at + 1) release dut.err_count_q;
        end while (!done && lat < 200);
        chk("done_reached", done, 1);
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_wr_en"}, wr_enable_init, 0);
        chk({tag, "_rd_en"}, rd_enable_init, 0);
        chk({tag, "_raddr"}, raddr_init, 0);
        chk({tag, "_waddr"}, waddr_init, 5'h1F);
        chk({tag, "_wdata"}, mem_data_in_init, 0);
    endtask

    initial begin
        int lat;
        int wb, rb, db;
        int k;
        logic done_seen;

        reset_n = 1'b0; start = 1'b0; read_only = 1'b0; abort = 1'b0; seed = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err_count, 0);
        chk("rst_first", first_err_addr, 0);
        chk_idle_bus("rst");
        chk("wclk_follows", wclk_init, clk);
        chk("rclk_follows", rclk_init, clk);

        // Ideal SRAM, seed 0: data equals address
        fmode = 0; wb = wr_cnt; rb = rd_cnt; db = wd_bad;
        run_test(8'h00, 1'b0, 0, lat);
        chk("t1_latency", lat, 66);
        chk("t1_err", err_count, 0);
        chk("t1_writes", wr_cnt - wb, 32);
        chk("t1_reads", rd_cnt - rb, 32);
        chk("t1_wdata", wd_bad - db, 0);
        chk("t1_mem5", mem[5], 8'h05);
        chk("t1_mem31", mem[31], 8'h1F);
        chk("t1_busy", busy, 0);

        // Single bit flip at 0x13
        fmode = 1; fault_addr = 5'h13; db = wd_bad;
        run_test(8'hA5, 1'b0, 0, lat);
        chk("t2_latency", lat, 66);
        chk("t2_err", err_count, 1);
        chk("t2_first", first_err_addr, 5'h13);
        chk("t2_wdata", wd_bad - db, 0);

        // Stuck-at-zero array
        fmode = 2;
        run_test(8'hFF, 1'b0, 0, lat);
        chk("t3_err", err_count, 32);
        chk("t3_first", first_err_addr, 5'h00);

        // Full test then read-only scrub of the same contents
        fmode = 0;
        run_test(8'h3C, 1'b0, 0, lat);
        chk("t4_full_err", err_count, 0);
        wb = wr_cnt; rb = rd_cnt;
        run_test(8'h3C, 1'b1, 0, lat);
        chk("t4_ro_latency", lat, 34);
        chk("t4_ro_writes", wr_cnt - wb, 0);
        chk("t4_ro_reads", rd_cnt - rb, 32);
        chk("t4_ro_err", err_count, 0);

        // Abort part way through WRITE
        cur_seed = 8'h11; seed = 8'h11; read_only = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(wr_enable_init && waddr_init == 5'd10) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reach_w10", wr_enable_init && waddr_init == 5'd10, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_done", done, 0);
        chk("t5_abort_err", err_count, 0);
        chk_idle_bus("t5_abort");
        start = 1'b1; abort = 1'b1; seed = 8'h22;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("t5_abort_beats_start", busy, 0);
        run_test(8'h11, 1'b0, 0, lat);
        chk("t5_rerun_latency", lat, 66);
        chk("t5_rerun_err", err_count, 0);

        // Counter preloaded near the top, then five more errors
        fmode = 3;
        run_test(8'h42, 1'b0, 3, lat);
        chk("t6_latency", lat, 66);
        chk("t6_err_sat", err_count, 16'hFFFF);
        chk("t6_first", first_err_addr, 5'h00);

        // Reset asserted mid-READ after one error has been logged
        fmode = 1; fault_addr = 5'h05;
        cur_seed = 8'h07; seed = 8'h07; read_only = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(rd_enable_init && raddr_init == 5'd10) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t7_reach_r10", rd_enable_init && raddr_init == 5'd10, 1);
        chk("t7_pre_err", err_count, 1);
        chk("t7_pre_first", first_err_addr, 5'h05);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_err", err_count, 0);
        chk("t7_rst_first", first_err_addr, 0);
        chk_idle_bus("t7_rst");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done || busy) done_seen = 1'b1;
        end
        chk("t7_no_done_after_reset", done_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sram_pattern_tester.md
SRAM_PATTERN_TESTER -- requirements
Module: sram_pattern_tester

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: SRAM word width.
REQ-002 SHALL have parameter AW, default 5: SRAM address width, so depth is 2^AW words.
REQ-003 SHALL have port clk, input, 1: the single clock; also drives wclk_init and rclk_init.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1: one-cycle test request, sampled only in IDLE.
REQ-006 SHALL have port read_only, input, 1: sampled with start; 1 = skip WRITE and check the existing contents (post-irradiation scrub).
REQ-007 SHALL have port abort, input, 1: forces IDLE.
REQ-008 SHALL have port seed, input, DATA_WIDTH: pattern seed, sampled with start.
REQ-009 SHALL have ports busy and done, output, 1 each: busy = test running; done = held high from test end until the next accepted start.
REQ-010 SHALL have port err_count, output, 16: mismatch count, saturating.
REQ-011 SHALL have port first_err_addr, output, AW: address of the first mismatch.
REQ-012 SHALL have port rd_enable_init / wr_enable_init, output, 1 each: SRAM read/write enables.
REQ-013 SHALL have ports wclk_init / rclk_init, output, 1 each: both equal clk.
REQ-014 SHALL have ports raddr_init / waddr_init, output, AW each: SRAM read/write addresses.
REQ-015 SHALL have port mem_data_in_init, output, DATA_WIDTH: write data.
REQ-016 SHALL have port mem_data_out_init, input, DATA_WIDTH: SRAM read data, valid one clk after the read enable/address cycle.

Function
REQ-017 SHALL define the pattern as pat(a) = seed_q XOR zero-extended a, where seed_q is seed latched at start; pat(a) SHALL be truncated to DATA_WIDTH if AW > DATA_WIDTH.
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, CHECK and DONE.
REQ-019 SHALL, in IDLE on start=1, clear err_count, clear the error flag, latch seed and read_only, reset the address counter to 0, and go to WRITE (read_only=0) or READ (read_only=1).
REQ-020 SHALL, in WRITE each cycle, drive wr_enable_init=1, waddr_init=cnt and mem_data_in_init=pat(cnt); at cnt = 2^AW-1 it SHALL wrap cnt to 0 and go to READ.
REQ-021 SHALL, in READ each cycle, drive rd_enable_init=1 and raddr_init=cnt and register {valid, cnt} into a one-stage compare pipe; at cnt = 2^AW-1 it SHALL go to CHECK.
REQ-022 SHALL, in every cycle where the pipe is valid (the READ cycles after the first, plus CHECK), compare mem_data_out_init with pat(pipe_addr).
REQ-023 SHALL, on a mismatch, increment err_count, saturating at 0xFFFF.
REQ-024 SHALL, on the first mismatch only, capture pipe_addr into first_err_addr.
REQ-025 SHALL go from CHECK to DONE, and DONE SHALL hold until start, which is then handled as in IDLE.
REQ-026 SHALL hold busy=1 in WRITE, READ and CHECK, and done=1 in DONE only.
REQ-027 SHALL, when not writing, drive wr_enable_init=0, waddr_init=all-ones and mem_data_in_init=0.
REQ-028 SHALL, when not reading, drive rd_enable_init=0 and raddr_init=0.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL, on abort in any state, go to IDLE next cycle, deassert both enables, clear pipe valid and leave err_count unchanged; abort SHALL win over a simultaneous start.
REQ-031 SHALL give a full test an exact latency of 2^(AW+1)+2 cycles from the start cycle to done=1, and a read_only test 2^AW+2 cycles.

Reset
REQ-032 SHALL, while reset_n=0, asynchronously force state=IDLE, busy=0, done=0, err_count=0, first_err_addr=0, cnt=0, pipe valid=0 and seed_q=0.
REQ-033 SHALL, during reset, hold both enables 0, raddr_init=0, waddr_init=all-ones and mem_data_in_init=0.
REQ-034 SHALL, on reset mid-test, discard the test; no done SHALL follow.

Structure
REQ-035 SHALL place the FSM state encoding and the err_count width constant (16) in a shared package, sram_test_pkg.
REQ-036 SHALL implement the one natural sub-module, sram_pattern_gen, as the combinational pat(a) function.

Verification
REQ-037 SHALL cover: AW=5, DATA_WIDTH=8, seed=0x00, full test on an ideal SRAM model -> 32 writes with data = address, 32 reads, done at start+66, err_count=0.
REQ-038 SHALL cover: seed=0xA5, model flips bit0 at address 0x13 -> err_count=1, first_err_addr=0x13.
REQ-039 SHALL cover: model stuck at 0x00 on all addresses, seed=0xFF -> err_count=32, first_err_addr=0x00.
REQ-040 SHALL cover: read_only=1 after a prior full test with seed 0x3C -> no write enables, done at start+34, err_count=0.
REQ-041 SHALL cover: abort at WRITE cycle 10 -> IDLE next cycle, wr_enable_init=0, busy=0, done=0; a following start runs a complete test.
REQ-042 SHALL cover: reset_n low mid-READ, and err_count forced to 0xFFFE with 5 more errors -> all outputs at reset values immediately on reset; err_count saturates at 0xFFFF.
